// File: rtl/rvc_expand_stage.sv
// rvc_expand_stage
//   Fetch-side stage after the I-cache address aligner. It expands a 16-bit RV32C
//   instruction into its 32-bit RV32I form, or passes a 32-bit word through unchanged.
//   The result is registered in a valid/ready stage that has one skid entry.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready aligner handshake; in_ready is registered (low while skid is full)
//   in_data, in_pc    aligned word and its PC
//   in_compressed     in_data[15:0] holds an RVC instruction
//   flush             redirect: drops both held entries and any word offered this cycle
//   out_valid/ready   decode handshake
//   out_instr/out_pc  expanded RV32I instruction and its PC
//   out_is_rvc        instruction came from a 16-bit encoding
//   out_illegal       reserved/illegal RVC; out_instr then carries the raw halfword
//   pc_inc            combinational fetch-PC increment (2 or 4)
module rvc_expand_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  input  logic            in_compressed,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            out_ready,
  output logic            in_ready,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_is_rvc,
  output logic            out_illegal,
  output logic [2:0]      pc_inc
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  // ---------------- expansion ----------------
  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm_ci, imm_4spn, imm_lw, imm_16sp, imm_lwsp, imm_swsp;
  logic [19:0] imm_lui;
  logic [20:1] imm_cj;
  logic [12:1] imm_cb;
  logic [31:0] exp_instr;
  logic        exp_illegal;

  assign c        = in_data[15:0];
  assign rd       = c[11:7];
  assign rs2      = c[6:2];
  assign rdp      = {2'b01, c[4:2]};
  assign rs1p     = {2'b01, c[9:7]};
  assign imm_ci   = {{6{c[12]}}, c[12], c[6:2]};
  assign imm_lui  = {{14{c[12]}}, c[12], c[6:2]};
  assign imm_4spn = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign imm_16sp = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
  assign imm_cj   = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
  assign imm_cb   = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};

  always_comb begin
    exp_instr   = in_data;
    exp_illegal = 1'b0;
    if (in_compressed) begin
      exp_instr = '0;
      case (c[1:0])
        2'b00: begin
          case (c[15:13])
            3'b000: begin
              exp_instr   = enc_i(imm_4spn, 5'd2, 3'b000, rdp, OPC_OPIMM);
              exp_illegal = (imm_4spn == '0);
            end
            3'b010:  exp_instr = enc_i(imm_lw, rs1p, 3'b010, rdp, OPC_LOAD);
            3'b110:  exp_instr = enc_s(imm_lw, rdp, rs1p);
            default: exp_illegal = 1'b1;
          endcase
        end
        2'b01: begin
          case (c[15:13])
            3'b000: exp_instr = enc_i(imm_ci, rd, 3'b000, rd, OPC_OPIMM);
            3'b001: exp_instr = enc_j(imm_cj, 5'd1);
            3'b010: exp_instr = enc_i(imm_ci, 5'd0, 3'b000, rd, OPC_OPIMM);
            3'b011: begin
              if (rd == 5'd2) begin
                exp_instr   = enc_i(imm_16sp, 5'd2, 3'b000, 5'd2, OPC_OPIMM);
                exp_illegal = (imm_16sp == '0);
              end else begin
                exp_instr   = {imm_lui, rd, OPC_LUI};
                exp_illegal = (imm_lui == '0);
              end
            end
            3'b100: begin
              case (c[11:10])
                2'b00: begin
                  exp_instr   = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OPIMM);
                  exp_illegal = c[12];
                end
                2'b01: begin
                  exp_instr   = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OPIMM);
                  exp_illegal = c[12];
                end
                2'b10: exp_instr = enc_i(imm_ci, rs1p, 3'b111, rs1p, OPC_OPIMM);
                default: begin
                  // c[12]=1 selects the RV64-only SUBW/ADDW slots
                  exp_illegal = c[12];
                  case (c[6:5])
                    2'b00:   exp_instr = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
                    2'b01:   exp_instr = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p);
                    2'b10:   exp_instr = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p);
                    default: exp_instr = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p);
                  endcase
                end
              endcase
            end
            3'b101:  exp_instr = enc_j(imm_cj, 5'd0);
            3'b110:  exp_instr = enc_b(imm_cb, rs1p, 3'b000);
            default: exp_instr = enc_b(imm_cb, rs1p, 3'b001);
          endcase
        end
        2'b10: begin
          case (c[15:13])
            3'b000: begin
              exp_instr   = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OPC_OPIMM);
              exp_illegal = c[12];
            end
            3'b010: begin
              exp_instr   = enc_i(imm_lwsp, 5'd2, 3'b010, rd, OPC_LOAD);
              exp_illegal = (rd == 5'd0);
            end
            3'b100: begin
              if (!c[12]) begin
                if (rs2 == 5'd0) begin
                  exp_instr   = enc_i('0, rd, 3'b000, 5'd0, OPC_JALR);
                  exp_illegal = (rd == 5'd0);
                end else begin
                  exp_instr = enc_r('0, rs2, 5'd0, 3'b000, rd);
                end
              end else if (rs2 == 5'd0) begin
                if (rd == 5'd0) exp_instr = 32'h0010_0073;
                else            exp_instr = enc_i('0, rd, 3'b000, 5'd1, OPC_JALR);
              end else begin
                exp_instr = enc_r('0, rs2, rd, 3'b000, rd);
              end
            end
            3'b110:  exp_instr = enc_s(imm_swsp, rs2, 5'd2);
            default: exp_illegal = 1'b1;
          endcase
        end
        default: exp_illegal = 1'b1;
      endcase
      if (exp_illegal) exp_instr = {16'h0000, c};
    end
  end

  assign pc_inc = in_compressed ? 3'd2 : 3'd4;

  // ---------------- skid-buffered register stage ----------------
  logic            out_valid_q, out_valid_d, out_is_rvc_q, out_is_rvc_d, out_illegal_q, out_illegal_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            skid_valid_q, skid_valid_d, skid_is_rvc_q, skid_is_rvc_d, skid_illegal_q, skid_illegal_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            accept;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_is_rvc_d   = out_is_rvc_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    skid_is_rvc_d  = skid_is_rvc_q;
    skid_illegal_d = skid_illegal_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Skid holds the older word, so it drains first; accept is impossible then.
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_instr_d   = skid_instr_q;
        out_pc_d      = skid_pc_q;
        out_is_rvc_d  = skid_is_rvc_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (accept) begin
        out_valid_d   = 1'b1;
        out_instr_d   = exp_instr;
        out_pc_d      = in_pc;
        out_is_rvc_d  = in_compressed;
        out_illegal_d = exp_illegal;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d   = 1'b1;
      skid_instr_d   = exp_instr;
      skid_pc_d      = in_pc;
      skid_is_rvc_d  = in_compressed;
      skid_illegal_d = exp_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= RESET_PC;
      out_is_rvc_q   <= 1'b0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= RESET_PC;
      skid_is_rvc_q  <= 1'b0;
      skid_illegal_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_is_rvc_q   <= out_is_rvc_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
      skid_is_rvc_q  <= skid_is_rvc_d;
      skid_illegal_q <= skid_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_is_rvc  = out_is_rvc_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_rvc_expand_stage.sv
// tb_rvc_expand_stage
//   Scoreboard bench for rvc_expand_stage. Stimulus pushes the reference result of each
//   accepted word; a monitor on the falling edge checks handshake signals and pops/compares
//   every word the stage hands to decode. The reference expands RVC from the ISA's
//   immediate bit-scatter tables using integer arithmetic.
module tb_rvc_expand_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
    logic        ill;
  } exp_t;

  // Target immediate bit for each source bit c[12] down to c[2]; -1 = not an immediate bit.
  typedef int pmap_t [11];
  localparam pmap_t M_CI   = '{5, -1, -1, -1, -1, -1, 4, 3, 2, 1, 0};
  localparam pmap_t M_CJ   = '{11, 4, 9, 8, 10, 6, 7, 3, 2, 1, 5};
  localparam pmap_t M_CB   = '{8, 4, 3, -1, -1, -1, 7, 6, 2, 1, 5};
  localparam pmap_t M_A16  = '{9, -1, -1, -1, -1, -1, 4, 6, 8, 7, 5};
  localparam pmap_t M_LWSP = '{5, -1, -1, -1, -1, -1, 4, 3, 2, 7, 6};
  localparam pmap_t M_SWSP = '{5, 4, 3, 2, 7, 6, -1, -1, -1, -1, -1};
  localparam pmap_t M_4SPN = '{5, 4, 9, 8, 7, 6, 2, 3, -1, -1, -1};
  localparam pmap_t M_LW   = '{5, 4, 3, -1, -1, -1, 2, 6, -1, -1, -1};

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_compressed, flush, out_ready;
  logic [31:0] in_data, in_pc;
  logic        in_ready, out_valid, out_is_rvc, out_illegal;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  pc_inc;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic model_ready = 1'b0;

  rvc_expand_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_compressed(in_compressed), .in_pc(in_pc), .flush(flush), .out_ready(out_ready),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_is_rvc(out_is_rvc), .out_illegal(out_illegal), .pc_inc(pc_inc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int scatter(int cc, pmap_t m);
    int r = 0;
    for (int i = 0; i < 11; i++)
      if (m[i] >= 0) r += ((cc >> (12 - i)) & 1) << m[i];
    return r;
  endfunction

  function automatic int sx(int v, int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic longint enc_i(int imm, int rs1, int f3, int rd, int op);
    return (longint'(imm & 4095) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12)
         | (longint'(rd) << 7) | longint'(op);
  endfunction

  function automatic longint enc_s(int imm, int rs2, int rs1);
    return (longint'((imm & 4095) >> 5) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
         | (longint'(2) << 12) | (longint'(imm & 31) << 7) | longint'('h23);
  endfunction

  function automatic longint enc_b(int imm, int rs1, int f3);
    longint m = longint'(imm & 8191);
    return (((m >> 12) & 1) << 31) | (((m >> 5) & 63) << 25) | (longint'(rs1) << 15)
         | (longint'(f3) << 12) | (((m >> 1) & 15) << 8) | (((m >> 11) & 1) << 7) | longint'('h63);
  endfunction

  function automatic longint enc_j(int imm, int rd);
    longint m = longint'(imm & 2097151);
    return (((m >> 20) & 1) << 31) | (((m >> 1) & 1023) << 21) | (((m >> 11) & 1) << 20)
         | (((m >> 12) & 255) << 12) | (longint'(rd) << 7) | longint'('h6f);
  endfunction

  function automatic longint enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return (longint'(f7) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
         | (longint'(f3) << 12) | (longint'(rd) << 7) | longint'('h33);
  endfunction

  function automatic exp_t ref_expand(logic [31:0] d, logic comp, logic [31:0] pc);
    exp_t   e;
    int     cc, f3, rd, rs2, rdp, rs1p, ci, v, b12;
    longint w = 0;
    logic   ill = 1'b0;
    e.pc = pc; e.rvc = comp; e.ill = 1'b0; e.instr = d;
    if (!comp) return e;
    cc   = int'(d[15:0]);
    f3   = (cc >> 13) & 7;
    rd   = (cc >> 7) & 31;
    rs2  = (cc >> 2) & 31;
    rdp  = 8 + ((cc >> 2) & 7);
    rs1p = 8 + ((cc >> 7) & 7);
    b12  = (cc >> 12) & 1;
    ci   = scatter(cc, M_CI);
    case (cc & 3)
      0: case (f3)
           0: begin v = scatter(cc, M_4SPN); ill = (v == 0); w = enc_i(v, 2, 0, rdp, 'h13); end
           2: w = enc_i(scatter(cc, M_LW), rs1p, 2, rdp, 'h03);
           6: w = enc_s(scatter(cc, M_LW), rdp, rs1p);
           default: ill = 1'b1;
         endcase
      1: case (f3)
           0: w = enc_i(sx(ci, 6), rd, 0, rd, 'h13);
           1: w = enc_j(sx(scatter(cc, M_CJ), 12), 1);
           2: w = enc_i(sx(ci, 6), 0, 0, rd, 'h13);
           3: if (rd == 2) begin
                v = sx(scatter(cc, M_A16), 10); ill = (v == 0); w = enc_i(v, 2, 0, 2, 'h13);
              end else begin
                v = sx(ci, 6); ill = (v == 0);
                w = (longint'(v & 'hfffff) << 12) | (longint'(rd) << 7) | longint'('h37);
              end
           4: case ((cc >> 10) & 3)
                0: begin ill = (ci >= 32); w = enc_i(ci, rs1p, 5, rs1p, 'h13); end
                1: begin ill = (ci >= 32); w = enc_i(ci + 'h400, rs1p, 5, rs1p, 'h13); end
                2: w = enc_i(sx(ci, 6), rs1p, 7, rs1p, 'h13);
                default: begin
                  ill = (b12 == 1);
                  case ((cc >> 5) & 3)
                    0: w = enc_r('h20, rdp, rs1p, 0, rs1p);
                    1: w = enc_r(0, rdp, rs1p, 4, rs1p);
                    2: w = enc_r(0, rdp, rs1p, 6, rs1p);
                    default: w = enc_r(0, rdp, rs1p, 7, rs1p);
                  endcase
                end
              endcase
           5: w = enc_j(sx(scatter(cc, M_CJ), 12), 0);
           6: w = enc_b(sx(scatter(cc, M_CB), 9), rs1p, 0);
           default: w = enc_b(sx(scatter(cc, M_CB), 9), rs1p, 1);
         endcase
      2: case (f3)
           0: begin ill = (ci >= 32); w = enc_i(ci, rd, 1, rd, 'h13); end
           2: begin ill = (rd == 0); w = enc_i(scatter(cc, M_LWSP), 2, 2, rd, 'h03); end
           4: if (b12 == 0) begin
                if (rs2 == 0) begin ill = (rd == 0); w = enc_i(0, rd, 0, 0, 'h67); end
                else w = enc_r(0, rs2, 0, 0, rd);
              end else begin
                if (rs2 == 0 && rd == 0) w = 'h0010_0073;
                else if (rs2 == 0) w = enc_i(0, rd, 0, 1, 'h67);
                else w = enc_r(0, rs2, rd, 0, rd);
              end
           6: w = enc_s(scatter(cc, M_SWSP), rs2, 2);
           default: ill = 1'b1;
         endcase
      default: ill = 1'b1;
    endcase
    e.ill   = ill;
    e.instr = ill ? {16'h0000, d[15:0]} : w[31:0];
    return e;
  endfunction

  function automatic exp_t known(logic [31:0] instr, logic [31:0] pc, logic rvc, logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.rvc = rvc; e.ill = ill;
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        model_ready = (sb.size() < 2);
        chk("in_ready", 32'(in_ready), 32'(model_ready));
        chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        chk("pc_inc", 32'(pc_inc), in_compressed ? 32'd2 : 32'd4);
        if (flush) begin
          sb.delete();
        end else if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_pc", out_pc, e.pc);
          chk("out_is_rvc", 32'(out_is_rvc), 32'(e.rvc));
          chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [31:0] d, input logic comp, input logic [31:0] pc,
                      input logic ordy, input logic fl, input exp_t e, output logic acc);
    in_valid = v; in_data = d; in_compressed = comp; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    acc = v && model_ready && !fl;
    if (acc) sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy, input logic fl);
    logic acc;
    step(1'b0, '0, 1'b0, '0, ordy, fl, known('0, '0, 1'b0, 1'b0), acc);
  endtask

  task automatic send(input logic [31:0] d, input logic comp, input logic ordy, input exp_t e);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 20) begin
      step(1'b1, d, comp, e.pc, ordy, 1'b0, e, acc);
      n++;
    end
    chk("accept_within_bound", 32'(acc), 32'd1);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    chk({tag, "_out_pc"}, out_pc, RST_PC);
    chk({tag, "_out_is_rvc"}, 32'(out_is_rvc), 32'd0);
    chk({tag, "_out_illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d, pc;
    logic        comp, acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_compressed = 1'b0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Known expansions
    send(32'h0000_4515, 1'b1, 1'b1, known(32'h0050_0513, 32'h100, 1'b1, 1'b0));
    send(32'hABCD_157D, 1'b1, 1'b1, known(32'hFFF5_0513, 32'h102, 1'b1, 1'b0));
    send(32'h0000_852E, 1'b1, 1'b1, known(32'h00B0_0533, 32'h104, 1'b1, 1'b0));
    send(32'h00A0_0093, 1'b0, 1'b1, known(32'h00A0_0093, 32'h106, 1'b0, 1'b0));
    send(32'h1234_0000, 1'b1, 1'b1, known(32'h0000_0000, 32'h10A, 1'b1, 1'b1));
    send(32'h0000_0010, 1'b1, 1'b1, known(32'h0000_0010, 32'h10C, 1'b1, 1'b1));
    repeat (2) idle(1'b1, 1'b0);

    // Back-pressure: A held, B in skid, C held off, then all drain in order
    send(32'h0000_4515, 1'b1, 1'b0, ref_expand(32'h4515, 1'b1, 32'h200));
    send(32'h0000_157D, 1'b1, 1'b0, ref_expand(32'h157D, 1'b1, 32'h202));
    step(1'b1, 32'h00A0_0093, 1'b0, 32'h204, 1'b0, 1'b0, ref_expand(32'h00A0_0093, 1'b0, 32'h204), acc);
    chk("stall_C_held_off", 32'(acc), 32'd0);
    send(32'h00A0_0093, 1'b0, 1'b1, ref_expand(32'h00A0_0093, 1'b0, 32'h204));
    repeat (3) idle(1'b1, 1'b0);
    chk("stall_drained", 32'(sb.size()), 32'd0);

    // Flush with both entries full
    send(32'h0000_852E, 1'b1, 1'b0, ref_expand(32'h852E, 1'b1, 32'h300));
    send(32'h0000_4515, 1'b1, 1'b0, ref_expand(32'h4515, 1'b1, 32'h302));
    step(1'b1, 32'h0000_157D, 1'b1, 32'h304, 1'b0, 1'b1, ref_expand(32'h157D, 1'b1, 32'h304), acc);
    repeat (2) idle(1'b1, 1'b0);

    // Reset with both entries full
    send(32'h0000_852E, 1'b1, 1'b0, ref_expand(32'h852E, 1'b1, 32'h400));
    send(32'h0000_4515, 1'b1, 1'b0, ref_expand(32'h4515, 1'b1, 32'h402));
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset_check("midreset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      d    = $urandom;
      comp = ($urandom_range(0, 9) < 7);
      if (comp && $urandom_range(0, 7) != 0) d[1:0] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) d[6:2] = 5'd0;
      if ($urandom_range(0, 5) == 0) d[11:7] = 5'd0;
      if ($urandom_range(0, 9) == 0) d[11:7] = 5'd2;
      pc = $urandom & 32'hFFFF_FFFE;
      step($urandom_range(0, 3) != 0, d, comp, pc, $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0, ref_expand(d, comp, pc), acc);
    end
    repeat (4) idle(1'b1, 1'b0);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
